factorial_engine: RTL

FACTORIAL_ENGINE -- requirements
Module: factorial_engine

---
 rtl/factorial_engine.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/factorial_engine.sv
// ---------------------------------------------------------------------------
// factorial_engine
//   Iterative factorial / double-factorial engine. One RES_W x SIZE multiply
//   per clock while in CALC; the operand counts down by 1 (n!) or by 2 (n!!)
//   until it drops to 1 or 0, at which point the accumulator is published.
//   If any partial product no longer fits in RES_W bits, the engine stops
//   right away and reports an all-ones result with overflow set.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for go; result/overflow hold their last values
//   CALC  | one multiply per cycle, counter stepping down
//   DONE  | result valid; held while go stays high, go=0 returns to IDLE
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   go          level start request, sampled in IDLE
//   mode        0 = n!, 1 = n!!  (latched at start)
//   n           unsigned operand (latched at start)
//   curr_state  FSM state (IDLE=0, CALC=1, DONE=2)
//   busy        high while in CALC
//   done        high while in DONE
//   overflow    result exceeded RES_W bits (valid while done=1)
//   result      computed value (valid while done=1)
// ---------------------------------------------------------------------------
module factorial_engine #(
    parameter int SIZE  = 8,
    parameter int RES_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             mode,
    input  logic [SIZE-1:0]  n,
    output logic [1:0]       curr_state,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [RES_W-1:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int PROD_W = RES_W + SIZE;

    state_t            r_state;
    logic [SIZE-1:0]   r_cnt;
    logic              r_mode;
    logic [RES_W-1:0]  r_acc;
    logic [RES_W-1:0]  r_result;
    logic              r_overflow;
    logic              r_busy;
    logic              r_done;

    logic [PROD_W-1:0] w_prod;
    logic              w_prod_ovf;
    logic              w_cnt_ge2;
    logic [SIZE-1:0]   w_step;
    logic [SIZE-1:0]   w_cnt_next;

    // Full-width product: both operands zero-extended to PROD_W so nothing
    // is lost before the overflow check.
    assign w_prod     = {{SIZE{1'b0}}, r_acc} * {{RES_W{1'b0}}, r_cnt};
    assign w_prod_ovf = |w_prod[PROD_W-1 -: SIZE];
    assign w_cnt_ge2  = (r_cnt > SIZE'(1));
    assign w_step     = r_mode ? SIZE'(2) : SIZE'(1);
    // Saturate at zero rather than wrapping.
    assign w_cnt_next = (r_cnt > w_step) ? (r_cnt - w_step) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_acc      <= RES_W'(1);
            r_cnt      <= '0;
            r_mode     <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (go) begin
                        r_cnt      <= n;
                        r_mode     <= mode;
                        r_acc      <= RES_W'(1);
                        r_overflow <= 1'b0;
                        r_state    <= ST_CALC;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                    end
                end

                ST_CALC: begin
                    if (!w_cnt_ge2) begin
                        r_result <= r_acc;
                        r_state  <= ST_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end else if (w_prod_ovf) begin
                        // Abort on the same edge; acc is left untouched.
                        r_overflow <= 1'b1;
                        r_result   <= '1;
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_acc <= w_prod[RES_W-1:0];
                        r_cnt <= w_cnt_next;
                    end
                end

                ST_DONE: begin
                    // Holding here while go stays high is what makes a
                    // continuously asserted go produce only one run.
                    if (!go) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign curr_state = r_state;
    assign busy       = r_busy;
    assign done       = r_done;
    assign overflow   = r_overflow;
    assign result     = r_result;

endmodule
